// File: rtl/vec_mem_seq.sv
// Vector memory sequencer: expands one vector load/store request into
// NUM_WORDS single-word RAM accesses (1-cycle read latency RAM).
module vec_mem_seq #(
   parameter int NUM_WORDS = 16,
   parameter int AW        = 16
) (
   input  logic                   Clk1,
   input  logic                   Reset,
   input  logic                   Start,
   input  logic                   Op,
   input  logic [AW-1:0]          BaseAddr,
   input  logic [16*NUM_WORDS-1:0] StoreData,
   input  logic [15:0]            DataIn,
   output logic [AW-1:0]          Addr,
   output logic                   RD,
   output logic                   WR,
   output logic [15:0]            DataOut,
   output logic                   Busy,
   output logic                   Done,
   output logic [16*NUM_WORDS-1:0] LoadData
);

   localparam int W = 16 * NUM_WORDS;
   localparam logic [4:0] LAST = 5'(NUM_WORDS - 1);

   typedef enum logic [2:0] {IDLE, LD_ISSUE, LD_DRAIN, ST_ISSUE, DONE} state_t;

   state_t         state, state_n;
   logic [4:0]     idx, idx_n;
   logic [AW-1:0]  addr_n;
   logic [15:0]    dout_n;
   logic [W-1:0]   sbuf, sbuf_n, ld_n;
   logic           cap_en, st_adv;
   logic [4:0]     cap_idx;

   always_ff @(posedge Clk1) begin
      if (Reset) begin
         state    <= IDLE;
         idx      <= '0;
         Addr     <= '0;
         DataOut  <= '0;
         sbuf     <= '0;
         LoadData <= '0;
      end else begin
         state    <= state_n;
         idx      <= idx_n;
         Addr     <= addr_n;
         DataOut  <= dout_n;
         sbuf     <= sbuf_n;
         LoadData <= ld_n;
      end
   end

   always_comb begin
      state_n = state;
      idx_n   = idx;
      addr_n  = Addr;
      dout_n  = DataOut;
      sbuf_n  = sbuf;
      ld_n    = LoadData;
      cap_en  = 1'b0;
      cap_idx = '0;
      st_adv  = 1'b0;
      case (state)
         IDLE, DONE: begin
            state_n = IDLE;
            if (Start) begin
               state_n = Op ? ST_ISSUE : LD_ISSUE;
               idx_n   = '0;
               addr_n  = BaseAddr;
               sbuf_n  = StoreData;
               if (Op) dout_n = StoreData[15:0];
            end
         end
         LD_ISSUE: begin
            // Word issued last cycle returns now; word 0 has nothing to capture yet.
            cap_en  = (idx != 5'd0);
            cap_idx = idx - 5'd1;
            if (idx == LAST) begin
               state_n = LD_DRAIN;
            end else begin
               idx_n  = idx + 5'd1;
               addr_n = Addr + AW'(1);
            end
         end
         LD_DRAIN: begin
            cap_en  = 1'b1;
            cap_idx = LAST;
            state_n = DONE;
         end
         ST_ISSUE: begin
            if (idx == LAST) begin
               state_n = DONE;
            end else begin
               st_adv = 1'b1;
               idx_n  = idx + 5'd1;
               addr_n = Addr + AW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
      for (int unsigned k = 0; k < NUM_WORDS; k++) begin
         if (cap_en && 5'(k) == cap_idx) ld_n[16*k +: 16] = DataIn;
         if (st_adv && 5'(k) == idx + 5'd1) dout_n = sbuf[16*k +: 16];
      end
   end

   assign RD   = (state == LD_ISSUE);
   assign WR   = (state == ST_ISSUE);
   assign Busy = (state == LD_ISSUE) || (state == LD_DRAIN) || (state == ST_ISSUE);
   assign Done = (state == DONE);

endmodule

// File: tb/tb_vec_mem_seq.sv
// Directed self-checking bench for vec_mem_seq with a 1-cycle-latency RAM model.
module tb_vec_mem_seq;

   logic          Clk1 = 1'b0;
   logic          Reset, Start, Op;
   logic [15:0]   BaseAddr;
   logic [255:0]  StoreData;
   logic [15:0]   DataIn;
   logic [15:0]   Addr;
   logic          RD, WR;
   logic [15:0]   DataOut;
   logic          Busy, Done;
   logic [255:0]  LoadData;

   int checks   = 0;
   int failures = 0;

   // Read contents (preloaded by the bench) and write capture kept apart.
   logic [15:0] rom  [0:65535];
   logic [15:0] wmem [0:65535];

   vec_mem_seq #(.NUM_WORDS(16), .AW(16)) dut (
      .Clk1(Clk1), .Reset(Reset), .Start(Start), .Op(Op), .BaseAddr(BaseAddr),
      .StoreData(StoreData), .DataIn(DataIn), .Addr(Addr), .RD(RD), .WR(WR),
      .DataOut(DataOut), .Busy(Busy), .Done(Done), .LoadData(LoadData)
   );

   always #5 Clk1 = ~Clk1;

   always @(posedge Clk1) begin
      if (RD) DataIn <= rom[Addr];
      if (WR) wmem[Addr] <= DataOut;
   end

   task automatic test_reset();
      @(negedge Clk1);
      Reset = 1'b1; Start = 1'b0; Op = 1'b0; BaseAddr = '0; StoreData = '0;
      repeat (2) @(negedge Clk1);
      checks++;
      if ({RD, WR, Busy, Done} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_ctrl got=%b exp=0000", {RD, WR, Busy, Done});
      end
      checks++;
      if ({Addr, DataOut} !== 32'h0) begin
         failures++;
         $display("FAIL reset_addr_dout got=%h exp=00000000", {Addr, DataOut});
      end
      checks++;
      if (LoadData !== '0) begin
         failures++;
         $display("FAIL reset_loaddata got=%h exp=0", LoadData);
      end
      Reset = 1'b0;
   endtask

   task automatic test_load();
      logic [19:0]  exp;
      logic [255:0] exp_ld;
      @(negedge Clk1);
      Start = 1'b1; Op = 1'b0; BaseAddr = 16'h0100;
      for (int c = 1; c <= 20; c++) begin
         @(negedge Clk1);
         if (c == 1) Start = 1'b0;
         exp = {(c <= 16), 1'b0, (c <= 17), (c == 18),
                (c <= 16) ? 16'h0100 + 16'(c - 1) : 16'h010F};
         checks++;
         if ({RD, WR, Busy, Done, Addr} !== exp) begin
            failures++;
            $display("FAIL load_cycle%0d got=%h exp=%h", c, {RD, WR, Busy, Done, Addr}, exp);
         end
      end
      for (int i = 0; i < 16; i++) exp_ld[16*i +: 16] = 16'h1000 + 16'(i);
      checks++;
      if (LoadData !== exp_ld) begin
         failures++;
         $display("FAIL load_data got=%h exp=%h", LoadData, exp_ld);
      end
   endtask

   task automatic test_store();
      logic [35:0]  exp;
      logic [255:0] exp_ld;
      @(negedge Clk1);
      Start = 1'b1; Op = 1'b1; BaseAddr = 16'h0200;
      for (int i = 0; i < 16; i++) StoreData[16*i +: 16] = 16'hA000 + 16'(i);
      for (int c = 1; c <= 19; c++) begin
         @(negedge Clk1);
         if (c == 1) begin
            Start = 1'b0;
            StoreData = {16{16'h5555}};
         end
         exp = {1'b0, (c <= 16), (c <= 16), (c == 17),
                (c <= 16) ? 16'h0200 + 16'(c - 1) : 16'h020F,
                (c <= 16) ? 16'hA000 + 16'(c - 1) : 16'hA00F};
         checks++;
         if ({RD, WR, Busy, Done, Addr, DataOut} !== exp) begin
            failures++;
            $display("FAIL store_cycle%0d got=%h exp=%h", c, {RD, WR, Busy, Done, Addr, DataOut}, exp);
         end
      end
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (wmem[16'h0200 + 16'(i)] !== 16'hA000 + 16'(i)) begin
            failures++;
            $display("FAIL store_ram%0d got=%h exp=%h", i, wmem[16'h0200 + 16'(i)], 16'hA000 + 16'(i));
         end
      end
      for (int i = 0; i < 16; i++) exp_ld[16*i +: 16] = 16'h1000 + 16'(i);
      checks++;
      if (LoadData !== exp_ld) begin
         failures++;
         $display("FAIL store_keeps_loaddata got=%h exp=%h", LoadData, exp_ld);
      end
   endtask

   task automatic test_wrap();
      logic [16:0]  exp;
      logic [255:0] exp_ld;
      @(negedge Clk1);
      Start = 1'b1; Op = 1'b0; BaseAddr = 16'hFFFE;
      for (int c = 1; c <= 20; c++) begin
         @(negedge Clk1);
         if (c == 1) Start = 1'b0;
         exp = {(c <= 16), (c <= 16) ? 16'hFFFE + 16'(c - 1) : 16'h000D};
         checks++;
         if ({RD, Addr} !== exp) begin
            failures++;
            $display("FAIL wrap_cycle%0d got=%h exp=%h", c, {RD, Addr}, exp);
         end
      end
      exp_ld[15:0]  = 16'hBEEF;
      exp_ld[31:16] = 16'hCAFE;
      for (int i = 2; i < 16; i++) exp_ld[16*i +: 16] = 16'h3000 + 16'(i - 2);
      checks++;
      if (LoadData !== exp_ld) begin
         failures++;
         $display("FAIL wrap_data got=%h exp=%h", LoadData, exp_ld);
      end
   endtask

   task automatic test_back_to_back();
      logic [19:0]  exp;
      logic [255:0] exp_ld;
      @(negedge Clk1);
      Start = 1'b1; Op = 1'b1; BaseAddr = 16'h0300;
      for (int i = 0; i < 16; i++) StoreData[16*i +: 16] = 16'h7700 + 16'(i);
      for (int c = 1; c <= 36; c++) begin
         @(negedge Clk1);
         if (c <= 16)      exp = {2'b01, 2'b10, 16'h0300 + 16'(c - 1)};
         else if (c == 17) exp = {2'b00, 2'b01, 16'h030F};
         else if (c <= 33) exp = {2'b10, 2'b10, 16'h0400 + 16'(c - 18)};
         else if (c == 34) exp = {2'b00, 2'b10, 16'h040F};
         else if (c == 35) exp = {2'b00, 2'b01, 16'h040F};
         else              exp = {2'b00, 2'b00, 16'h040F};
         checks++;
         if ({RD, WR, Busy, Done, Addr} !== exp) begin
            failures++;
            $display("FAIL b2b_cycle%0d got=%h exp=%h", c, {RD, WR, Busy, Done, Addr}, exp);
         end
         case (c)
            1:  Start = 1'b0;
            5:  begin Start = 1'b1; Op = 1'b0; BaseAddr = 16'h0999; end
            6:  Start = 1'b0;
            17: begin Start = 1'b1; Op = 1'b0; BaseAddr = 16'h0400; end
            18: Start = 1'b0;
            default: ;
         endcase
      end
      checks++;
      if (wmem[16'h0305] !== 16'h7705) begin
         failures++;
         $display("FAIL b2b_store_word got=%h exp=7705", wmem[16'h0305]);
      end
      for (int i = 0; i < 16; i++) exp_ld[16*i +: 16] = 16'h4400 + 16'(i);
      checks++;
      if (LoadData !== exp_ld) begin
         failures++;
         $display("FAIL b2b_load_data got=%h exp=%h", LoadData, exp_ld);
      end
   endtask

   task automatic test_reset_mid();
      logic [19:0] exp;
      @(negedge Clk1);
      Start = 1'b1; Op = 1'b0; BaseAddr = 16'h0100;
      for (int c = 1; c <= 25; c++) begin
         @(negedge Clk1);
         if (c <= 5) exp = {2'b10, 2'b10, 16'h0100 + 16'(c - 1)};
         else        exp = {2'b00, 2'b00, 16'h0000};
         checks++;
         if ({RD, WR, Busy, Done, Addr} !== exp) begin
            failures++;
            $display("FAIL rstmid_cycle%0d got=%h exp=%h", c, {RD, WR, Busy, Done, Addr}, exp);
         end
         if (c == 6) begin
            checks++;
            if (LoadData !== '0) begin
               failures++;
               $display("FAIL rstmid_loaddata got=%h exp=0", LoadData);
            end
         end
         case (c)
            1: Start = 1'b0;
            5: begin Reset = 1'b1; Start = 1'b1; Op = 1'b1; end
            6: begin Reset = 1'b0; Start = 1'b0; end
            default: ;
         endcase
      end
      checks++;
      if (LoadData !== '0) begin
         failures++;
         $display("FAIL rstmid_loaddata_end got=%h exp=0", LoadData);
      end
   endtask

   initial begin
      Reset = 1'b1; Start = 1'b0; Op = 1'b0; BaseAddr = '0; StoreData = '0;
      for (int a = 0; a < 65536; a++) rom[a] = 16'h0000;
      for (int i = 0; i < 16; i++) begin
         rom[16'h0100 + i] = 16'h1000 + 16'(i);
         rom[16'h0400 + i] = 16'h4400 + 16'(i);
      end
      rom[16'hFFFE] = 16'hBEEF;
      rom[16'hFFFF] = 16'hCAFE;
      for (int i = 0; i < 14; i++) rom[i] = 16'h3000 + 16'(i);

      test_reset();
      test_load();
      test_store();
      test_wrap();
      test_back_to_back();
      test_reset_mid();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vec_mem_seq.md
VEC_MEM_SEQ -- requirements
Module: vec_mem_seq

Sits between CVP14 vector load/store issue and staticram. Converts one vector memory request into NUM_WORDS single-word RAM accesses.

Interface
REQ-001 Parameter: NUM_WORDS, default 16, words per vector transfer (1..16).
REQ-002 Parameter: AW, default 16, RAM address width.
REQ-003 Port: Clk1  in  1  sole clock; all state updates on rising edge.
REQ-004 Port: Reset  in  1  synchronous, active-high reset.
REQ-005 Port: Start  in  1  request strobe, sampled only when idle or in DONE.
REQ-006 Port: Op  in  1  0 = vector load, 1 = vector store; sampled with Start.
REQ-007 Port: BaseAddr  in  AW  first word address; sampled with Start.
REQ-008 Port: StoreData  in  16*NUM_WORDS  store payload, word i at bits [16i+15:16i]; sampled with Start.
REQ-009 Port: DataIn  in  16  read data from RAM.
REQ-010 Port: Addr  out  AW  RAM address.
REQ-011 Port: RD  out  1  RAM read strobe.
REQ-012 Port: WR  out  1  RAM write strobe.
REQ-013 Port: DataOut  out  16  RAM write data.
REQ-014 Port: Busy  out  1  transfer in progress.
REQ-015 Port: Done  out  1  one-cycle completion pulse.
REQ-016 Port: LoadData  out  16*NUM_WORDS  assembled load result, word i at [16i+15:16i].

Function
REQ-017 FSM states: IDLE, LD_ISSUE, LD_DRAIN, ST_ISSUE, DONE; all registered outputs.
REQ-018 IDLE/DONE + Start=1: latch Op, BaseAddr, StoreData (internal buffer), clear index i=0; go to LD_ISSUE (Op=0) or ST_ISSUE (Op=1).
REQ-019 Start while Busy=1: ignored, no queuing.
REQ-020 RAM read latency fixed at 1 cycle: DataIn at cycle c is the word addressed by RD in cycle c-1.
REQ-021 LD_ISSUE: RD=1, WR=0, Addr=BaseAddr+i, one word per cycle, i=0..NUM_WORDS-1; after i=NUM_WORDS-1 go to LD_DRAIN.
REQ-022 Load capture: DataIn captured into LoadData word i at end of the cycle following issue of word i; LD_DRAIN (RD=0) captures the final word, then goes to DONE.
REQ-023 ST_ISSUE: WR=1, RD=0, Addr=BaseAddr+i, DataOut=buffered word i; after i=NUM_WORDS-1 go to DONE.
REQ-024 Address arithmetic modulo 2^AW: BaseAddr+i wraps (0xFFFF+1 -> 0x0000), no error flag.
REQ-025 RD and WR never both 1 in any cycle; both 0 in IDLE, LD_DRAIN, DONE.
REQ-026 Busy=1 in LD_ISSUE, LD_DRAIN, ST_ISSUE; 0 in IDLE and DONE.
REQ-027 DONE lasts exactly one cycle with Done=1, then IDLE unless Start=1 (back-to-back start accepted from DONE).
REQ-028 Latency, Start sampled at edge T: load Done high in cycle T+NUM_WORDS+2; store Done high in cycle T+NUM_WORDS+1.
REQ-029 LoadData holds its value from Done until the first capture of the next load; stores leave LoadData unchanged.
REQ-030 Addr and DataOut hold their last driven value when RD=WR=0.

Reset
REQ-031 Reset=1 at a rising edge: state IDLE, i=0, Addr=0, RD=0, WR=0, DataOut=0, Busy=0, Done=0, LoadData=0, store buffer=0.
REQ-032 Reset mid-transfer: abort at that edge, no further RD/WR strobes, no Done pulse; Reset dominates a simultaneous Start.

Verification
REQ-033 Load, BaseAddr=0x0100, RAM[0x0100+i]=0x1000+i -> RD high 16 cycles, Addr 0x0100..0x010F, Done at T+18, LoadData word i = 0x1000+i.
REQ-034 Store, BaseAddr=0x0200, StoreData word i=0xA000+i, StoreData changed after T -> WR high 16 cycles, RAM[0x0200+i]=0xA000+i, Done at T+17.
REQ-035 Wrap: load with BaseAddr=0xFFFE -> Addr sequence 0xFFFE, 0xFFFF, 0x0000..0x000D.
REQ-036 Start pulsed during Busy -> ignored; Start in DONE cycle -> new transfer, first strobe next cycle.
REQ-037 Reset asserted after 5 load issues -> RD=0 next cycle, Busy=0, Done never pulses, LoadData=0.
